// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues credit-limited word fetches and
// queues returned words for the decoder. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int          CW  = $clog2(QDEPTH) + 1;
    localparam int          PW  = $clog2(QDEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          started;
    logic          trap;

    logic [31:0]   q_data [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];

    logic          credit_ok;
    logic          accept;
    logic          push;
    logic          pop;
    logic          queue_nonempty;
    logic [CW-1:0] outstanding_nxt;
    logic [31:0]   redirect_target;

    // Target address seen by the fetch counters on a redirect.
    // NOTE: every signal assigned in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        redirect_target = redirect_pc;
`ifndef FETCH_MISALIGN_TRAP_EN
        redirect_target[1:0] = 2'b00;
`endif
    end

`ifndef FETCH_MISALIGN_TRAP_EN
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    assign queue_nonempty  = (count != '0);
    assign credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(QDEPTH);

    assign imem_req_valid  = started && !rst && !trap && !redirect_valid && credit_ok;
    assign imem_req_addr   = fetch_pc;
    assign accept          = imem_req_valid && imem_req_ready;

    assign push            = imem_rsp_valid && (drop_cnt == '0);
    assign inst_valid      = queue_nonempty && !trap;
    assign pop             = inst_valid && inst_ready;

    assign inst            = queue_nonempty ? q_data[head] : NOP;
    assign inst_pc         = queue_nonempty ? q_pc[head]   : rsp_pc;

    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Every request still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop_cnt <= outstanding_nxt;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    tail   <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: queue storage is not reset; entries are only ever read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push && !redirect_valid) begin
            q_data[tail] <= imem_rsp_data;
            q_pc[tail]   <= rsp_pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            trap <= 1'b0;
        end else if (redirect_valid) begin
            trap <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign fetch_misalign = trap;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: in-order memory model plus a
// request-level reference model (stale-tagged in-flight list and entry queue).
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    inst_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        inflight [$];
    ent_t        q [$];
    logic [31:0] m_fetch_pc;
    bit          m_run;
    bit          m_trap;
    int          cyc        = 0;
    int          last_due   = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    int          compared   = 0;
    int          mismatched = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        inflight.delete();
        q.delete();
        m_fetch_pc = RESET_PC;
        m_trap     = 1'b0;
        m_run      = 1'b0;
        last_due   = cyc;
        #2;
        check("rst_req_valid",  32'(imem_req_valid), 32'd0);
        check("rst_req_addr",   imem_req_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst",       inst, NOP);
        check("rst_inst_pc",    inst_pc, RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_misalign",   32'(fetch_misalign), 32'd0);
`endif
        @(posedge clk);
        #1;
        cyc++;
        m_run = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic tick(input bit rq_rdy, input bit in_rdy, input bit redir, input logic [31:0] rpc);
        bit          rsp;
        bit          exp_req;
        bit          exp_iv;
        bit          acc;
        bit          pop;
        logic [31:0] exp_inst;
        logic [31:0] tgt;
        req_t        r;
        ent_t        e;
        int          due;

        rsp = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(inflight[0].addr) : $urandom();
        imem_req_ready = rq_rdy;
        inst_ready     = in_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #2;

        exp_req  = m_run && !m_trap && !redir && ((q.size() + inflight.size()) < QDEPTH);
        exp_iv   = (q.size() > 0) && !m_trap;
        exp_inst = (q.size() > 0) ? q[0].data : NOP;
        check("req_valid",  32'(imem_req_valid), 32'(exp_req));
        check("req_addr",   imem_req_addr, m_fetch_pc);
        check("inst_valid", 32'(inst_valid), 32'(exp_iv));
        check("inst",       inst, exp_inst);
        if (exp_iv) check("inst_pc", inst_pc, q[0].pc);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign",   32'(fetch_misalign), 32'(m_trap));
`endif

        acc = exp_req && rq_rdy;
        pop = exp_iv && in_rdy;
        r.addr  = '0;
        r.due   = 0;
        r.stale = 1'b1;
        if (rsp) begin
            r = inflight.pop_front();
            if (!r.stale) begin
                assert (q.size() < QDEPTH) else begin
                    mismatched++;
                    $error("FAIL rsp_into_full: queue size %0d required below %0d", q.size(), QDEPTH);
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (rsp && !r.stale) begin
            e.pc   = r.addr;
            e.data = mem_word(r.addr);
            q.push_back(e);
        end
        if (acc) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            r.addr  = m_fetch_pc;
            r.due   = due;
            r.stale = 1'b0;
            inflight.push_back(r);
            last_due   = due;
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redir) begin
            q.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            tgt = rpc;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_trap = (rpc[1:0] != 2'b00);
`else
            tgt[1:0] = 2'b00;
`endif
            m_fetch_pc = tgt;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] rnd;

        // Streaming with a 1-cycle memory and an always-ready decoder.
        do_reset();
        repeat (12) tick(1'b1, 1'b1, 1'b0, '0);

        // Decoder stalled: credits run out at QDEPTH, then drain and resume.
        do_reset();
        repeat (8) tick(1'b1, 1'b0, 1'b0, '0);
        repeat (8) tick(1'b1, 1'b1, 1'b0, '0);

        // Memory request channel stalled for 3 cycles mid-stream.
        do_reset();
        repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
        repeat (3) tick(1'b0, 1'b1, 1'b0, '0);
        repeat (8) tick(1'b1, 1'b1, 1'b0, '0);

        // Redirect with two requests outstanding on a 3-cycle memory.
        lat_min = 3;
        lat_max = 3;
        do_reset();
        repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        repeat (14) tick(1'b1, 1'b1, 1'b0, '0);

        // Redirect coinciding with an inst pop while the queue is full.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        repeat (5) tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        repeat (6) tick(1'b1, 1'b1, 1'b0, '0);

        // Back-to-back redirects with responses in flight; last one wins.
        lat_min = 2;
        lat_max = 4;
        repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_1000);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_2000);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_3000);
        repeat (12) tick(1'b1, 1'b1, 1'b0, '0);

        // PC wraps modulo 2^32.
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (16) tick(1'b1, 1'b1, 1'b0, '0);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps; an aligned one clears it.
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        repeat (5) tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        repeat (10) tick(1'b1, 1'b1, 1'b0, '0);
`else
        // Low redirect bits are ignored.
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        repeat (10) tick(1'b1, 1'b1, 1'b0, '0);
`endif

        // Randomized traffic with occasional redirects and mid-run resets.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            if ((i % 150) == 149 && $urandom_range(0, 1) == 1) begin
                do_reset();
            end
            rnd = $urandom();
`ifdef FETCH_MISALIGN_TRAP_EN
            if ($urandom_range(0, 3) == 0) rnd[1:0] = 2'($urandom_range(1, 3));
            else                            rnd[1:0] = 2'b00;
`endif
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, rnd);
        end
        repeat (10) tick(1'b1, 1'b1, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
